// File: rtl/muldiv_seq_if.sv
// Control-unit handshake and operand/result bus for the sequential mul/div unit.
interface muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, input busy, done, div_by_zero, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, div_by_zero, hi, lo);
endinterface

// File: rtl/muldiv_seq.sv
// Multi-cycle signed multiply (radix-2 Booth) and signed divide (restoring) feeding HI/LO.
// One iteration per cycle; start/busy/done handshake toward the control unit.
module muldiv_seq #(
  parameter int         WIDTH  = 32,
  parameter logic [3:0] OP_MUL = 4'd10,
  parameter logic [3:0] OP_DIV = 4'd11
) (
  input logic          clock,
  input logic          clear,
  muldiv_seq_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MUL  = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [2*WIDTH:0] acc_q,   acc_d;
  logic             e_q,     e_d;
  // opa: multiplier during MUL, dividend/quotient shift register during DIV
  logic [WIDTH-1:0] opa_q,   opa_d;
  // opb: multiplicand during MUL, divisor magnitude during DIV
  logic [WIDTH-1:0] opb_q,   opb_d;
  logic [WIDTH-1:0] rem_q,   rem_d;
  logic             sa_q,    sa_d;
  logic             sb_q,    sb_d;
  logic [WIDTH-1:0] hi_q,    hi_d;
  logic [WIDTH-1:0] lo_q,    lo_d;
  logic             dbz_q,   dbz_d;

  logic [WIDTH:0]   acc_top, b_ext, booth_sum;
  logic [2*WIDTH:0] booth_sh;
  logic [WIDTH:0]   r_sh, r_diff;
  logic [WIDTH-1:0] q_sh;
  logic             last;

  always_comb begin
    last    = (count_q == CW'(WIDTH-1));

    // Booth step: 33-bit add/sub so b = most-negative needs no special case
    acc_top = acc_q[2*WIDTH:WIDTH];
    b_ext   = {opb_q[WIDTH-1], opb_q};
    case ({opa_q[count_q], e_q})
      2'b10:   booth_sum = acc_top - b_ext;
      2'b01:   booth_sum = acc_top + b_ext;
      default: booth_sum = acc_top;
    endcase
    booth_sh = {booth_sum[WIDTH], booth_sum, acc_q[WIDTH-1:1]};

    // Restoring divide step, MSB of dividend enters the partial remainder
    r_sh    = {rem_q, opa_q[WIDTH-1]};
    r_diff  = r_sh - {1'b0, opb_q};
    q_sh    = {opa_q[WIDTH-2:0], 1'b0};

    state_d = state_q;
    count_d = count_q;
    acc_d   = acc_q;
    e_d     = e_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    rem_d   = rem_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dbz_d   = dbz_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (bus.start && bus.op == OP_MUL) begin
          state_d = S_MUL;
          opa_d   = bus.a;
          opb_d   = bus.b;
          acc_d   = '0;
          e_d     = 1'b0;
          count_d = '0;
          dbz_d   = 1'b0;
        end else if (bus.start && bus.op == OP_DIV) begin
          if (bus.b == '0) begin
            state_d = S_DONE;
            hi_d    = bus.a;
            lo_d    = '1;
            dbz_d   = 1'b1;
          end else begin
            state_d = S_DIV;
            opa_d   = bus.a[WIDTH-1] ? -bus.a : bus.a;
            opb_d   = bus.b[WIDTH-1] ? -bus.b : bus.b;
            sa_d    = bus.a[WIDTH-1];
            sb_d    = bus.b[WIDTH-1];
            rem_d   = '0;
            count_d = '0;
            dbz_d   = 1'b0;
          end
        end
      end
      S_MUL: begin
        acc_d   = booth_sh;
        e_d     = opa_q[count_q];
        count_d = count_q + CW'(1);
        if (last) begin
          {hi_d, lo_d} = booth_sh[2*WIDTH-1:0];
          state_d      = S_DONE;
        end
      end
      S_DIV: begin
        opa_d = q_sh;
        rem_d = r_sh[WIDTH-1:0];
        if (!r_diff[WIDTH]) begin
          rem_d    = r_diff[WIDTH-1:0];
          opa_d[0] = 1'b1;
        end
        count_d = count_q + CW'(1);
        if (last) state_d = S_FIX;
      end
      S_FIX: begin
        // remainder follows the dividend's sign; quotient wraps for MIN / -1
        lo_d    = (sa_q ^ sb_q) ? -opa_q : opa_q;
        hi_d    = sa_q ? -rem_q : rem_q;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= S_IDLE;
      count_q <= '0;
      acc_q   <= '0;
      e_q     <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      rem_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      e_q     <= e_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      rem_q   <= rem_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.busy        = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
  assign bus.done        = (state_q == S_DONE);
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
endmodule
